cache_line_fill: RTL and testbench
==================================

CACHE_LINE_FILL -- requirements
Module: cache_line_fill

Interface
REQ-001 Parameter: PABITS, default 36, physical address width; tag width TW = PABITS-12.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MissReq  input  1  read-miss request; sampled only in IDLE.
REQ-005 MissAddr  input  PABITS-2  word address of the miss: {tag[TW], index[8], offset[2]}.
REQ-006 Busy  output  1  high in every state except IDLE.
REQ-007 MemReadReq  output  1  single-word read request to memory.
REQ-008 MemAddr  output  PABITS-2  word address of the current request: {tag, index, current offset}.
REQ-009 MemReady  input  1  memory data valid; qualified only while MemReadReq is high.
REQ-010 MemData  input  32  read data, valid when MemReady is high.
REQ-011 SetTag  output  TW  tag driven to the set for invalidate and validate.
REQ-012 SetIndex  output  8  index driven to the set for invalidate and validate.
REQ-013 InvalidateLine  output  1  one-cycle invalidate strobe to the set.
REQ-014 ValidateLine  output  1  one-cycle validate strobe to the set.
REQ-015 LineIndex  output  8  fill index to the set; equals the latched index.
REQ-016 LineOffset  output  2  fill word offset to the set.
REQ-017 LineIn  output  32  fill word to the set; equals MemData.
REQ-018 FillLine  output  1  fill-word strobe to the set.
REQ-019 CritWord  output  32  missed word forwarded to the pipeline.
REQ-020 CritValid  output  1  one-cycle strobe qualifying CritWord.
REQ-021 Done  output  1  one-cycle strobe marking fill completion.

Function
REQ-022 States: IDLE, INVAL, FETCH, VALID. Encoding is two bits.
REQ-023 In IDLE, MissReq=1 shall latch tag, index, and start offset S from MissAddr, and the next state shall be INVAL.
REQ-024 INVAL lasts one cycle: InvalidateLine=1, SetTag/SetIndex = latched values, then FETCH. No stale hit is possible during the fill.
REQ-025 FETCH: MemReadReq=1 and MemAddr stable until MemReady=1. A MemReady in the same cycle as the first MemReadReq is legal.
REQ-026 Each MemReady in FETCH shall drive FillLine=1, LineIn=MemData, and LineOffset=current offset in that same cycle (combinational).
REQ-027 Fetch order is critical-word-first with wrap: S, S+1, S+2, S+3 mod 4 (for example, S=2 gives 2,3,0,1). A 2-bit word counter advances on each MemReady.
REQ-028 The first accepted word (offset S) shall also assert CritValid=1 with CritWord=MemData in the same cycle.
REQ-029 After the 4th MemReady, the next state shall be VALID. VALID lasts one cycle: ValidateLine=1 and Done=1, SetTag/SetIndex = latched values, then IDLE.
REQ-030 Latency with MemReady held high: MissReq at edge N gives INVAL in cycle N+1, words in N+2..N+5, VALID in N+6, and IDLE with Busy=0 in N+7.
REQ-031 MissReq outside IDLE shall be ignored. A new miss may be accepted in the cycle after VALID.
REQ-032 MemReady while MemReadReq=0 shall be ignored, with no fill and no counter advance.
REQ-033 Strobes are mutually exclusive: InvalidateLine, FillLine, and ValidateLine are never high in the same cycle.
REQ-034 When MemReadReq=0, MemAddr shall hold its last value and LineOffset shall equal the current counter value.

Reset
REQ-035 Reset shall take priority over all inputs and force IDLE; the counter, latched tag/index, and offset shall clear to 0.
REQ-036 After reset, all strobes and MemReadReq shall be 0, Busy=0, and CritWord=0.
REQ-037 Reset mid-fill shall abort the fill with no ValidateLine. The line stays invalid because INVAL preceded the fill.

Structure
REQ-038 A shared package shall hold the state encodings, LINE_WORDS=4, INDEX_BITS=8, OFFSET_BITS=2, and the TW derivation.
REQ-039 The block shall be a single module with no sub-module; the wrap counter and FSM are inline.

Verification
REQ-040 Reset, then MissAddr={24'h654321,8'h76,2'b00} with MemReady always 1: cycles carry InvalidateLine, then FillLine at offsets 0,1,2,3, then ValidateLine+Done; CritWord=first MemData; Busy falls in N+7.
REQ-041 Miss at offset 2'b10, index 8'hff, data 11111111/22222222/33333333/44444444: LineOffset sequence 2,3,0,1; CritWord=32'h11111111; MemAddr offsets track 2,3,0,1.
REQ-042 MemReady delayed 3 cycles per word: MemReadReq and MemAddr stay stable during the waits, FillLine=0 while waiting, and exactly 4 FillLine pulses occur.
REQ-043 Reset asserted after the 2nd word: next cycle IDLE, Busy=0, ValidateLine never asserted.
REQ-044 MissReq held high through a whole fill: exactly one fill occurs, then a second fill starts in the cycle after Done; a spurious MemReady during INVAL causes no fill.
REQ-045 Connected to a 128x256 read-only set: after Done, a read of tag 24'h654321, index 8'h76, each offset returns Hit=1, Valid=1, and the filled word.

Source files
------------

// File: rtl/cache_line_fill_pkg.sv
// Shared definitions for the cache line fill engine: state encoding, line
// geometry and the tag width derived from the physical address width.
package cache_line_fill_pkg;

  localparam int LINE_WORDS  = 4;
  localparam int INDEX_BITS  = 8;
  localparam int OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INVAL = 2'd1,
    ST_FETCH = 2'd2,
    ST_VALID = 2'd3
  } fill_state_t;

  // Tag is everything above the 4 KiB page offset.
  function automatic int tag_width(input int pabits);
    return pabits - 12;
  endfunction

endpackage

// File: rtl/cache_line_fill_if.sv
// Signal bundle between the fill engine (slave) and its surroundings:
// miss request, memory read port, set write port and pipeline forward.
interface cache_line_fill_if
  import cache_line_fill_pkg::*;
#(
  parameter int PABITS = 36
);
  localparam int TW = tag_width(PABITS);

  logic                   MissReq;
  logic [PABITS-3:0]      MissAddr;
  logic                   Busy;
  logic                   MemReadReq;
  logic [PABITS-3:0]      MemAddr;
  logic                   MemReady;
  logic [31:0]            MemData;
  logic [TW-1:0]          SetTag;
  logic [INDEX_BITS-1:0]  SetIndex;
  logic                   InvalidateLine;
  logic                   ValidateLine;
  logic [INDEX_BITS-1:0]  LineIndex;
  logic [OFFSET_BITS-1:0] LineOffset;
  logic [31:0]            LineIn;
  logic                   FillLine;
  logic [31:0]            CritWord;
  logic                   CritValid;
  logic                   Done;

  modport master (
    output MissReq, MissAddr, MemReady, MemData,
    input  Busy, MemReadReq, MemAddr, SetTag, SetIndex, InvalidateLine,
           ValidateLine, LineIndex, LineOffset, LineIn, FillLine,
           CritWord, CritValid, Done
  );

  modport slave (
    input  MissReq, MissAddr, MemReady, MemData,
    output Busy, MemReadReq, MemAddr, SetTag, SetIndex, InvalidateLine,
           ValidateLine, LineIndex, LineOffset, LineIn, FillLine,
           CritWord, CritValid, Done
  );

endinterface

// File: rtl/cache_line_fill.sv
// Critical-word-first cache line fill: invalidate the line, fetch four words
// with wrap starting at the missed offset, then validate the line.
module cache_line_fill
  import cache_line_fill_pkg::*;
#(
  parameter int PABITS = 36
) (
  input logic              clock,
  input logic              reset,
  cache_line_fill_if.slave bus
);

  localparam int TW = tag_width(PABITS);

  fill_state_t            state_reg;
  logic [TW-1:0]          tag_reg;
  logic [INDEX_BITS-1:0]  index_reg;
  logic [OFFSET_BITS-1:0] start_reg;
  logic [OFFSET_BITS-1:0] off_reg;
  logic [31:0]            crit_reg;
  logic [PABITS-3:0]      addr_hold_reg;

  logic              fetching;
  logic              accept;
  logic              first_word;
  logic              last_word;
  logic [PABITS-3:0] cur_addr;

  assign fetching   = (state_reg == ST_FETCH);
  assign accept     = fetching && bus.MemReady;
  // Offsets in a fill are all distinct, so position is recovered from the counter alone.
  assign first_word = (off_reg == start_reg);
  assign last_word  = (off_reg == start_reg + OFFSET_BITS'(LINE_WORDS - 1));
  assign cur_addr   = {tag_reg, index_reg, off_reg};

  assign bus.Busy           = (state_reg != ST_IDLE);
  assign bus.MemReadReq     = fetching;
  assign bus.MemAddr        = fetching ? cur_addr : addr_hold_reg;
  assign bus.SetTag         = tag_reg;
  assign bus.SetIndex       = index_reg;
  assign bus.InvalidateLine = (state_reg == ST_INVAL);
  assign bus.ValidateLine   = (state_reg == ST_VALID);
  assign bus.Done           = (state_reg == ST_VALID);
  assign bus.LineIndex      = index_reg;
  assign bus.LineOffset     = off_reg;
  assign bus.LineIn         = bus.MemData;
  assign bus.FillLine       = accept;
  assign bus.CritValid      = accept && first_word;
  assign bus.CritWord       = (accept && first_word) ? bus.MemData : crit_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      tag_reg       <= '0;
      index_reg     <= '0;
      start_reg     <= '0;
      off_reg       <= '0;
      crit_reg      <= '0;
      addr_hold_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.MissReq) begin
            tag_reg   <= bus.MissAddr[PABITS-3 -: TW];
            index_reg <= bus.MissAddr[OFFSET_BITS +: INDEX_BITS];
            start_reg <= bus.MissAddr[OFFSET_BITS-1:0];
            off_reg   <= bus.MissAddr[OFFSET_BITS-1:0];
            state_reg <= ST_INVAL;
          end
        end
        ST_INVAL: state_reg <= ST_FETCH;
        ST_FETCH: begin
          if (bus.MemReady) begin
            off_reg       <= off_reg + 1'b1;
            addr_hold_reg <= cur_addr;
            if (first_word) crit_reg <= bus.MemData;
            if (last_word) state_reg <= ST_VALID;
          end
        end
        ST_VALID: state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_fill.sv
// Scoreboard bench for cache_line_fill: stimulus queues expected set strobes,
// a monitor pops and checks them; a small set model checks the filled line.
module tb_cache_line_fill;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_line_fill_if #(.PABITS(36)) bus();

  cache_line_fill #(.PABITS(36)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          kind;   // 0 invalidate, 1 fill, 2 validate
    logic [23:0] tag;
    logic [7:0]  idx;
    logic [1:0]  off;
    logic [31:0] data;
    bit          crit;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  logic [23:0] set_tag   [256];
  bit          set_valid [256];
  logic [31:0] set_data  [256][4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_ev(input int kind, input logic [23:0] tag, input logic [7:0] idx,
                                  input logic [1:0] off, input logic [31:0] data, input bit crit);
    ev_t e;
    e.kind = kind; e.tag = tag; e.idx = idx; e.off = off; e.data = data; e.crit = crit;
    exp_q.push_back(e);
  endfunction

  // Set model written by the DUT strobes
  always @(posedge clk) begin
    if (bus.InvalidateLine) set_valid[bus.SetIndex] <= 1'b0;
    if (bus.FillLine) set_data[bus.LineIndex][bus.LineOffset] <= bus.LineIn;
    if (bus.ValidateLine) begin
      set_valid[bus.SetIndex] <= 1'b1;
      set_tag[bus.SetIndex]   <= bus.SetTag;
    end
  end

  // Monitor: sample between the stimulus edge and the next rising edge
  always @(negedge clk) begin
    int n;
    int kind;
    ev_t e;
    #3;
    n = int'(bus.InvalidateLine) + int'(bus.FillLine) + int'(bus.ValidateLine);
    check("strobe_excl", 64'(n <= 1), 64'(1));
    check("done_vs_validate", 64'(bus.Done), 64'(bus.ValidateLine));
    if (n >= 1) begin
      kind = bus.InvalidateLine ? 0 : (bus.FillLine ? 1 : 2);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(kind), 64'hffff);
      end else begin
        e = exp_q.pop_front();
        check("ev_kind", 64'(kind), 64'(e.kind));
        if (e.kind == 1) begin
          check("line_offset", 64'(bus.LineOffset), 64'(e.off));
          check("line_in", 64'(bus.LineIn), 64'(e.data));
          check("line_index", 64'(bus.LineIndex), 64'(e.idx));
          check("mem_addr", 64'(bus.MemAddr), 64'({e.tag, e.idx, e.off}));
          check("crit_valid", 64'(bus.CritValid), 64'(e.crit));
          if (e.crit) check("crit_word", 64'(bus.CritWord), 64'(e.data));
        end else begin
          check("set_tag", 64'(bus.SetTag), 64'(e.tag));
          check("set_index", 64'(bus.SetIndex), 64'(e.idx));
        end
      end
    end else begin
      check("crit_idle", 64'(bus.CritValid), 64'(0));
    end
  end

  // One miss; n_words < 4 applies reset after that many words.
  task automatic do_fill(input logic [23:0] tag, input logic [7:0] idx, input logic [1:0] s,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] d3, input int delay, input int n_words, input bit hold_req);
    logic [31:0] d [4];
    logic [1:0]  off;
    d = '{d0, d1, d2, d3};
    check("idle_busy", 64'(bus.Busy), 64'(0));
    push_ev(0, tag, idx, 2'd0, 32'd0, 1'b0);
    for (int w = 0; w < n_words; w++) begin
      off = s + 2'(w);
      push_ev(1, tag, idx, off, d[w], w == 0);
    end
    if (n_words == 4) push_ev(2, tag, idx, 2'd0, 32'd0, 1'b0);
    bus.MissReq  = 1'b1;
    bus.MissAddr = {tag, idx, s};
    bus.MemReady = (delay == 0);
    bus.MemData  = 32'hdeadbeef;
    @(negedge clk);
    check("inval_busy", 64'(bus.Busy), 64'(1));
    check("inval_no_req", 64'(bus.MemReadReq), 64'(0));
    bus.MissReq = hold_req;
    @(negedge clk);
    for (int w = 0; w < n_words; w++) begin
      off = s + 2'(w);
      for (int k = 0; k < delay; k++) begin
        bus.MemReady = 1'b0;
        bus.MemData  = 32'h0bad0bad;
        #1;
        check("wait_req", 64'(bus.MemReadReq), 64'(1));
        check("wait_addr", 64'(bus.MemAddr), 64'({tag, idx, off}));
        check("wait_fill", 64'(bus.FillLine), 64'(0));
        @(negedge clk);
      end
      bus.MemReady = 1'b1;
      bus.MemData  = d[w];
      @(negedge clk);
    end
    bus.MemData = 32'hdeadbeef;
    if (n_words < 4) begin
      reset        = 1'b1;
      bus.MemReady = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", 64'(bus.Busy), 64'(0));
      check("abort_req", 64'(bus.MemReadReq), 64'(0));
      check("abort_crit", 64'(bus.CritWord), 64'(0));
      return;
    end
    if (delay != 0) bus.MemReady = 1'b0;
    check("valid_busy", 64'(bus.Busy), 64'(1));
    check("valid_no_req", 64'(bus.MemReadReq), 64'(0));
    @(negedge clk);
    bus.MemReady = 1'b0;
    check("done_busy", 64'(bus.Busy), 64'(0));
    check("crit_held", 64'(bus.CritWord), 64'(d0));
  endtask

  initial begin
    reset        = 1'b1;
    bus.MissReq  = 1'b0;
    bus.MissAddr = '0;
    bus.MemReady = 1'b0;
    bus.MemData  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(bus.Busy), 64'(0));
    check("rst_req", 64'(bus.MemReadReq), 64'(0));
    check("rst_strobes", 64'({bus.InvalidateLine, bus.FillLine, bus.ValidateLine, bus.Done}), 64'(0));
    check("rst_crit", 64'(bus.CritWord), 64'(0));
    @(negedge clk);

    // Aligned miss, memory always ready
    do_fill(24'h654321, 8'h76, 2'b00, 32'hcafe0000, 32'hcafe0001, 32'hcafe0002, 32'hcafe0003, 0, 4, 1'b0);
    check("rd_hit", 64'(set_valid[8'h76] && set_tag[8'h76] == 24'h654321), 64'(1));
    check("rd_w0", 64'(set_data[8'h76][0]), 64'h cafe0000);
    check("rd_w1", 64'(set_data[8'h76][1]), 64'h cafe0001);
    check("rd_w2", 64'(set_data[8'h76][2]), 64'h cafe0002);
    check("rd_w3", 64'(set_data[8'h76][3]), 64'h cafe0003);

    // Wrapped miss at offset 2, last index
    do_fill(24'h00abcd, 8'hff, 2'b10, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 4, 1'b0);
    check("wrap_w2", 64'(set_data[8'hff][2]), 64'h11111111);
    check("wrap_w3", 64'(set_data[8'hff][3]), 64'h22222222);
    check("wrap_w0", 64'(set_data[8'hff][0]), 64'h33333333);
    check("wrap_w1", 64'(set_data[8'hff][1]), 64'h44444444);
    check("wrap_hit", 64'(set_valid[8'hff] && set_tag[8'hff] == 24'h00abcd), 64'(1));

    // Slow memory: three wait cycles per word
    do_fill(24'h123456, 8'h05, 2'b01, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'h0f0f0f0f, 32'hf0f0f0f0, 3, 4, 1'b0);
    check("slow_w1", 64'(set_data[8'h05][1]), 64'ha5a5a5a5);
    check("slow_w0", 64'(set_data[8'h05][0]), 64'hf0f0f0f0);

    // Reset after the second word: the line must stay invalid
    do_fill(24'h777777, 8'h33, 2'b11, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 0, 2, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_line_invalid", 64'(set_valid[8'h33]), 64'(0));

    // MissReq held high: back-to-back fills, second accepted right after VALID
    do_fill(24'h0000aa, 8'h10, 2'b00, 32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003, 0, 4, 1'b1);
    do_fill(24'h0000bb, 8'h11, 2'b01, 32'h20000001, 32'h20000002, 32'h20000003, 32'h20000000, 0, 4, 1'b0);
    check("b2b_first_hit", 64'(set_valid[8'h10] && set_tag[8'h10] == 24'h0000aa), 64'(1));
    check("b2b_second_w1", 64'(set_data[8'h11][1]), 64'h20000001);

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
